// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline flush/stall controller.
// State encodings, the ERET except_type code and the default exception vectors.
package pipe_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_HOLD  = 2'd1,
        FLUSH_REDIR = 2'd2
    } flush_state_e;

    localparam logic [31:0] ERET_CODE_DEF = 32'h0000_000e;
    localparam logic [31:0] VEC_BEV1_DEF  = 32'hbfc0_0380;
    localparam logic [31:0] VEC_BEV0_DEF  = 32'h8000_0180;

endpackage

// File: rtl/pipe_flush_ctrl_stall_resolve.sv
// Per-stage stall resolution: a request at stage j holds stage j and every
// lower-index (older-in-pipe) stage; a kill masks the whole vector.
module pipe_flush_ctrl_stall_resolve #(
    parameter int NUM_STAGES = 5
) (
    input  logic [NUM_STAGES-1:0] i_stall_req,
    input  logic                  i_kill,
    output logic [NUM_STAGES-1:0] o_stall
);

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_stage
            assign o_stall[g] = ~i_kill & (|i_stall_req[NUM_STAGES-1:g]);
        end
    endgenerate

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush controller: flushes on a committed exception/ERET, holds the
// flush for FLUSH_CYCLES, then offers the redirect PC to fetch via valid/ready.
module pipe_flush_ctrl
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int          NUM_STAGES   = 5,
    parameter int          EXC_W        = 32,
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] ERET_CODE    = ERET_CODE_DEF,
    parameter logic [31:0] VEC_BEV1     = VEC_BEV1_DEF,
    parameter logic [31:0] VEC_BEV0     = VEC_BEV0_DEF,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [EXC_W-1:0]      except_type_cp0,
    input  logic [ADDR_W-1:0]     cp0_epc,
    input  logic                  cp0_status_bev,
    input  logic [NUM_STAGES-1:0] stall_req,
    output logic                  flush,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_W-1:0]     new_pc,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(FLUSH_CYCLES - 1);

    flush_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_new_pc, w_target;
    logic              w_exc, w_is_eret, w_capture, w_flush, w_rv;

    assign w_exc     = |except_type_cp0;
    assign w_is_eret = (except_type_cp0 == EXC_W'(ERET_CODE));
    assign w_target  = w_is_eret      ? cp0_epc :
                       cp0_status_bev ? ADDR_W'(VEC_BEV1) : ADDR_W'(VEC_BEV0);

    // Outputs are gated by resetn so a held reset shows quiet outputs even
    // though flush/stall are otherwise combinational on the inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flush     = 1'b0;
        w_rv        = 1'b0;
        w_capture   = 1'b0;
        if (resetn) begin
            case (r_state)
                FLUSH_IDLE: begin
                    if (w_exc) begin
                        w_flush   = 1'b1;
                        w_capture = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = FLUSH_HOLD;
                            w_cnt_nxt   = HOLD_INIT;
                        end else begin
                            w_state_nxt = FLUSH_REDIR;
                        end
                    end
                end
                FLUSH_HOLD: begin
                    w_flush = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = FLUSH_REDIR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                FLUSH_REDIR: begin
                    w_flush = 1'b1;
                    w_rv    = 1'b1;
                    if (redirect_ready) w_state_nxt = FLUSH_IDLE;
                end
                default: begin
                    w_state_nxt = FLUSH_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= FLUSH_IDLE;
            r_cnt    <= '0;
            r_new_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) r_new_pc <= w_target;
        end
    end

    pipe_flush_ctrl_stall_resolve #(
        .NUM_STAGES (NUM_STAGES)
    ) u_stall_resolve (
        .i_stall_req (stall_req),
        .i_kill      (w_flush | ~resetn),
        .o_stall     (stall)
    );

    assign flush          = w_flush;
    assign redirect_valid = w_rv;
    assign new_pc         = r_new_pc;
    assign busy           = (r_state != FLUSH_IDLE);

endmodule
